// File: rtl/otter_mem_ctrl.sv
// rtl/otter_mem_ctrl.sv - handshaked byte-enabled data/instruction memory controller for OTTER
//
// Purpose: accepts one load/store at a time from the multicycle control unit,
// drives an internally inferred byte-enabled single-port RAM, and returns an
// extended load result or a fault flag with a one-cycle done pulse.
//
// Optional feature macro: OTTER_MEM_RANGE_CHECK_EN (upper address bits must be zero).
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset
//   i_req    access request, sampled while o_busy=0
//   i_we     1=store, 0=load
//   i_addr   byte address
//   i_wdata  right-aligned store data
//   i_size   00=byte, 01=half, 10=word, 11=illegal
//   i_sign   0=sign-extend load, 1=zero-extend load
//   o_busy   access in flight
//   o_done   one-cycle completion pulse
//   o_rdata  extended load result, held until next done
//   o_error  fault flag, valid with done
module otter_mem_ctrl #(
  parameter int ADDR_WIDTH   = 13,
  parameter int BUS_WIDTH    = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req,
  input  logic                 i_we,
  input  logic [BUS_WIDTH-1:0] i_addr,
  input  logic [BUS_WIDTH-1:0] i_wdata,
  input  logic [1:0]           i_size,
  input  logic                 i_sign,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [BUS_WIDTH-1:0] o_rdata,
  output logic                 o_error
);

  localparam int         DEPTH    = 2 ** (ADDR_WIDTH - 2);
  // Final value of the latency counter while in ACCESS (READ_LATENCY-1 cycles).
  localparam logic [2:0] LAST_CNT = (READ_LATENCY > 1) ? 3'(READ_LATENCY - 2) : 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  state_t r_state, w_next;

  logic [31:0]           r_mem [0:DEPTH-1];
  logic [31:0]           r_rd_word;
  logic [2:0]            r_cnt;
  logic [1:0]            r_off;
  logic [1:0]            r_size;
  logic                  r_sign;
  logic [31:0]           r_rdata;
  logic                  r_error;

  logic [ADDR_WIDTH-3:0] w_idx;
  logic                  w_accept;
  logic                  w_align_fault;
  logic                  w_range_fault;
  logic                  w_fault;
  logic                  w_last;
  logic [3:0]            w_be;
  logic [31:0]           w_wrep;

  assign w_idx = i_addr[ADDR_WIDTH-1:2];

  always_comb begin
    w_align_fault = (i_size == 2'b11) ||
                    ((i_size == 2'b01) && i_addr[0]) ||
                    ((i_size == 2'b10) && (i_addr[1:0] != 2'b00));
  end

`ifdef OTTER_MEM_RANGE_CHECK_EN
  assign w_range_fault = |i_addr[BUS_WIDTH-1:ADDR_WIDTH];
`else
  // Upper bits alias onto the decoded range.
  logic w_unused_upper;
  assign w_unused_upper = ^i_addr[BUS_WIDTH-1:ADDR_WIDTH];
  assign w_range_fault  = 1'b0;
`endif

  assign w_fault  = w_align_fault || w_range_fault;
  // ACCESS is the only busy state; reset wins over a same-edge request.
  assign w_accept = i_req && !i_rst && (r_state != S_ACCESS);
  assign w_last   = (r_cnt == LAST_CNT);

  always_comb begin
    w_be   = 4'b0000;
    w_wrep = i_wdata[31:0];
    case (i_size)
      2'b00: begin
        w_be   = 4'b0001 << i_addr[1:0];
        w_wrep = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        w_be   = i_addr[1] ? 4'b1100 : 4'b0011;
        w_wrep = {2{i_wdata[15:0]}};
      end
      2'b10: w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  function automatic logic [31:0] f_extend(input logic [31:0] word, input logic [1:0] off,
                                           input logic [1:0] sz, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   f_extend = sgn ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   f_extend = sgn ? {16'b0, h} : {{16{h[15]}}, h};
      default: f_extend = word;
    endcase
  endfunction

  // RAM: stores commit at the acceptance edge; loads register the word there.
  always_ff @(posedge i_clk) begin
    if (w_accept && !w_fault) begin
      if (i_we) begin
        for (int b = 0; b < 4; b++) begin
          if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wrep[8*b +: 8];
        end
      end else begin
        r_rd_word <= r_mem[w_idx];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      S_IDLE, S_RESP: begin
        o_done = (r_state == S_RESP);
        w_next = S_IDLE;
        if (w_accept) begin
          w_next = (!w_fault && !i_we && (READ_LATENCY > 1)) ? S_ACCESS : S_RESP;
        end
      end
      S_ACCESS: begin
        o_busy = 1'b1;
        if (w_last) w_next = S_RESP;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= 3'd0;
      r_off   <= 2'd0;
      r_size  <= 2'd0;
      r_sign  <= 1'b0;
      r_rdata <= 32'd0;
      r_error <= 1'b0;
    end else if (w_accept) begin
      r_cnt  <= 3'd0;
      r_off  <= i_addr[1:0];
      r_size <= i_size;
      r_sign <= i_sign;
      if (w_fault) begin
        r_error <= 1'b1;
        r_rdata <= 32'd0;
      end else if (i_we) begin
        r_error <= 1'b0;
      end else if (READ_LATENCY == 1) begin
        // Single-cycle load: result must be ready in the very next cycle.
        r_error <= 1'b0;
        r_rdata <= f_extend(r_mem[w_idx], i_addr[1:0], i_size, i_sign);
      end
    end else if (r_state == S_ACCESS) begin
      r_cnt <= r_cnt + 3'd1;
      if (w_last) begin
        r_error <= 1'b0;
        r_rdata <= f_extend(r_rd_word, r_off, r_size, r_sign);
      end
    end
  end

  assign o_rdata = r_rdata;
  assign o_error = r_error;

endmodule

// File: tb/tb_otter_mem_ctrl.sv
// tb/tb_otter_mem_ctrl.sv - directed self-checking bench for otter_mem_ctrl
module tb_otter_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        t_we;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic [1:0]  t_size;
  logic        t_sign;
  logic        req1, req3, req4;
  logic        busy1, done1, err1;
  logic        busy3, done3, err3;
  logic        busy4, done4, err4;
  logic [31:0] rd1, rd3, rd4;

  int checks = 0;
  int errors = 0;
  int done_seen;

  always #5 clk = ~clk;

  otter_mem_ctrl #(.ADDR_WIDTH(13), .BUS_WIDTH(32), .READ_LATENCY(1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_req(req1), .i_we(t_we), .i_addr(t_addr),
    .i_wdata(t_wdata), .i_size(t_size), .i_sign(t_sign),
    .o_busy(busy1), .o_done(done1), .o_rdata(rd1), .o_error(err1));

  otter_mem_ctrl #(.ADDR_WIDTH(13), .BUS_WIDTH(32), .READ_LATENCY(3)) u3 (
    .i_clk(clk), .i_rst(rst), .i_req(req3), .i_we(t_we), .i_addr(t_addr),
    .i_wdata(t_wdata), .i_size(t_size), .i_sign(t_sign),
    .o_busy(busy3), .o_done(done3), .o_rdata(rd3), .o_error(err3));

  otter_mem_ctrl #(.ADDR_WIDTH(13), .BUS_WIDTH(32), .READ_LATENCY(4)) u4 (
    .i_clk(clk), .i_rst(rst), .i_req(req4), .i_we(t_we), .i_addr(t_addr),
    .i_wdata(t_wdata), .i_size(t_size), .i_sign(t_sign),
    .o_busy(busy4), .o_done(done4), .o_rdata(rd4), .o_error(err4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic sg);
    t_we    = we;
    t_addr  = a;
    t_wdata = d;
    t_size  = sz;
    t_sign  = sg;
  endtask

  // One access on the latency-1 instance; returns in the cycle after acceptance.
  task automatic acc1(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic sg);
    drive(we, a, d, sz, sg);
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req1 = 1'b0;
    req3 = 1'b0;
    req4 = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", {31'b0, busy1}, 32'd0);
    chk("rst_done", {31'b0, done1}, 32'd0);
    chk("rst_error", {31'b0, err1}, 32'd0);
    chk("rst_rdata", rd1, 32'd0);

    // Word store then back-to-back word load.
    acc1(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0);
    chk("sw_done", {31'b0, done1}, 32'd1);
    chk("sw_busy", {31'b0, busy1}, 32'd0);
    chk("sw_err", {31'b0, err1}, 32'd0);
    chk("sw_rdata_held", rd1, 32'd0);
    acc1(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    chk("lw_done", {31'b0, done1}, 32'd1);
    chk("lw_rdata", rd1, 32'hDEADBEEF);
    chk("lw_err", {31'b0, err1}, 32'd0);
    tick();
    chk("lw_done_pulse", {31'b0, done1}, 32'd0);
    chk("lw_rdata_hold", rd1, 32'hDEADBEEF);

    // Byte lanes and extension.
    acc1(1'b1, 32'h20, 32'h11223344, 2'b10, 1'b0);
    acc1(1'b1, 32'h21, 32'h00000080, 2'b00, 1'b0);
    acc1(1'b0, 32'h21, 32'h0, 2'b00, 1'b0);
    chk("lb_signed", rd1, 32'hFFFFFF80);
    acc1(1'b0, 32'h21, 32'h0, 2'b00, 1'b1);
    chk("lb_unsigned", rd1, 32'h00000080);
    acc1(1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
    chk("lw_after_sb", rd1, 32'h11228044);
    acc1(1'b1, 32'h22, 32'h0000A5B6, 2'b01, 1'b0);
    acc1(1'b0, 32'h22, 32'h0, 2'b01, 1'b0);
    chk("lh_signed", rd1, 32'hFFFFA5B6);
    acc1(1'b0, 32'h20, 32'h0, 2'b01, 1'b1);
    chk("lh_low_unsigned", rd1, 32'h00008044);
    acc1(1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
    chk("lw_after_sh", rd1, 32'hA5B68044);

    // Misalignment and illegal size.
    acc1(1'b0, 32'h13, 32'h0, 2'b01, 1'b0);
    chk("lh_mis_err", {31'b0, err1}, 32'd1);
    chk("lh_mis_rdata", rd1, 32'd0);
    chk("lh_mis_busy", {31'b0, busy1}, 32'd0);
    chk("lh_mis_done", {31'b0, done1}, 32'd1);
    acc1(1'b1, 32'h12, 32'h12345678, 2'b10, 1'b0);
    chk("sw_mis_err", {31'b0, err1}, 32'd1);
    chk("sw_mis_busy", {31'b0, busy1}, 32'd0);
    acc1(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    chk("lw_unmod", rd1, 32'hDEADBEEF);
    chk("lw_unmod_err", {31'b0, err1}, 32'd0);
    acc1(1'b0, 32'h10, 32'h0, 2'b11, 1'b0);
    chk("size11_err", {31'b0, err1}, 32'd1);
    chk("size11_rdata", rd1, 32'd0);

    // Upper address bits: fault with range check, alias to word 0 without.
    acc1(1'b1, 32'h0, 32'h01020304, 2'b10, 1'b0);
    acc1(1'b1, 32'h2000, 32'hCAFEF00D, 2'b10, 1'b0);
`ifdef OTTER_MEM_RANGE_CHECK_EN
    chk("range_err", {31'b0, err1}, 32'd1);
    acc1(1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
    chk("range_word0", rd1, 32'h01020304);
`else
    chk("alias_err", {31'b0, err1}, 32'd0);
    acc1(1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
    chk("alias_word0", rd1, 32'hCAFEF00D);
`endif
    tick();

    // Latency 3 with req held high throughout.
    drive(1'b1, 32'h40, 32'h55AA55AA, 2'b10, 1'b0);
    req3 = 1'b1;
    tick();
    chk("l3_store_done", {31'b0, done3}, 32'd1);
    drive(1'b0, 32'h40, 32'h0, 2'b10, 1'b0);
    tick();
    chk("l3_c1_busy", {31'b0, busy3}, 32'd1);
    chk("l3_c1_done", {31'b0, done3}, 32'd0);
    chk("l3_c1_rdata_held", rd3, 32'd0);
    tick();
    chk("l3_c2_busy", {31'b0, busy3}, 32'd1);
    chk("l3_c2_done", {31'b0, done3}, 32'd0);
    tick();
    chk("l3_c3_done", {31'b0, done3}, 32'd1);
    chk("l3_c3_busy", {31'b0, busy3}, 32'd0);
    chk("l3_c3_rdata", rd3, 32'h55AA55AA);
    tick();
    chk("l3_second_accept", {31'b0, busy3}, 32'd1);
    req3 = 1'b0;
    tick();
    chk("l3_second_c2", {31'b0, busy3}, 32'd1);
    tick();
    chk("l3_second_done", {31'b0, done3}, 32'd1);
    tick();
    chk("l3_idle", {31'b0, done3 | busy3}, 32'd0);

    // Latency 4 full load, then reset mid-ACCESS.
    drive(1'b1, 32'h0, 32'h0BADF00D, 2'b10, 1'b0);
    req4 = 1'b1;
    tick();
    chk("l4_store_done", {31'b0, done4}, 32'd1);
    drive(1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
    tick();
    req4 = 1'b0;
    chk("l4_c1_busy", {31'b0, busy4}, 32'd1);
    tick();
    tick();
    chk("l4_c3_busy", {31'b0, busy4}, 32'd1);
    tick();
    chk("l4_c4_done", {31'b0, done4}, 32'd1);
    chk("l4_c4_rdata", rd4, 32'h0BADF00D);
    tick();
    req4 = 1'b1;
    tick();
    req4 = 1'b0;
    tick();
    chk("l4_abort_busy_pre", {31'b0, busy4}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("l4_abort_busy", {31'b0, busy4}, 32'd0);
    chk("l4_abort_done", {31'b0, done4}, 32'd0);
    chk("l4_abort_rdata", rd4, 32'd0);
    chk("l4_abort_err", {31'b0, err4}, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done4 === 1'b1 || busy4 === 1'b1) done_seen++;
    end
    chk("l4_no_late_done", done_seen, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
